// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with masked load/store
// Optional DMEM_RANGE_CHK_EN adds the derr port and rejects addresses beyond DEPTH words.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [3:0]  dre,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dready,
  output logic        dstall
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic        derr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        we_q, we_d;
  logic [3:0]        dre_q, dre_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic              commit;
  logic              req_err;
  logic              unused_bits;

  logic [31:0] mem_q [DEPTH];

`ifdef DMEM_RANGE_CHK_EN
  assign req_err     = |daddr[31:ADDR_W+2];
  assign unused_bits = ^daddr[1:0];
`else
  assign req_err     = 1'b0;
  assign unused_bits = ^{daddr[31:ADDR_W+2], daddr[1:0]};
`endif

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // The *_d request copies already hold the access being committed, whether it
  // came straight from the inputs (zero wait states) or from the latched copy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    dre_d   = dre_q;
    din_d   = din_q;
    err_d   = err_q;
    dout_d  = dout_q;
    commit  = 1'b0;
    dstall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dce) begin
          dstall = 1'b1;
          idx_d  = daddr[ADDR_W+1:2];
          we_d   = we;
          dre_d  = dre;
          din_d  = din;
          err_d  = req_err;
          cnt_d  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dstall = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      if (err_d || (we_d != 4'd0)) dout_d = 32'd0;
      else                         dout_d = mem_q[idx_d] & lane_mask(dre_d);
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 4'd0;
      dre_q   <= 4'd0;
      din_q   <= 32'd0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      dre_q   <= dre_d;
      din_q   <= din_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge cpu_clk_50M) begin
    if (commit && !err_d && !cpu_rst) begin
      for (int k = 0; k < 4; k++) begin
        if (we_d[k]) mem_q[idx_d][8*k +: 8] <= din_d[8*k +: 8];
      end
    end
  end

  assign dout   = dout_q;
  assign dready = (state_q == S_RESP);
`ifdef DMEM_RANGE_CHK_EN
  assign derr   = (state_q == S_RESP) && err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        dce_s   [2];
  logic [31:0] daddr_s [2];
  logic [3:0]  we_s    [2];
  logic [3:0]  dre_s   [2];
  logic [31:0] din_s   [2];
  logic [31:0] dout_s  [2];
  logic        dready_s[2];
  logic        dstall_s[2];
`ifdef DMEM_RANGE_CHK_EN
  logic        derr_s  [2];
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut_w2 (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .dce(dce_s[0]), .daddr(daddr_s[0]),
    .we(we_s[0]), .dre(dre_s[0]), .din(din_s[0]), .dout(dout_s[0]),
    .dready(dready_s[0]), .dstall(dstall_s[0])
`ifdef DMEM_RANGE_CHK_EN
    , .derr(derr_s[0])
`endif
  );

  dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .dce(dce_s[1]), .daddr(daddr_s[1]),
    .we(we_s[1]), .dre(dre_s[1]), .din(din_s[1]), .dout(dout_s[1]),
    .dready(dready_s[1]), .dstall(dstall_s[1])
`ifdef DMEM_RANGE_CHK_EN
    , .derr(derr_s[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // One complete handshake; expected data and latency come from the reference array.
  task automatic access(input int u, input logic [31:0] a, input logic [3:0] w,
                        input logic [3:0] r, input logic [31:0] d);
    int          lat;
    int          idx;
    logic        err;
    logic [31:0] mask;
    logic [31:0] exp;
    err = 1'b0;
`ifdef DMEM_RANGE_CHK_EN
    err = (a[31:12] != 20'd0);
`endif
    idx  = int'(a[11:2]);
    mask = 32'd0;
    for (int k = 0; k < 4; k++) if (r[k]) mask = mask | (32'hFF << (8 * k));
    exp = (err || (w != 4'd0)) ? 32'd0 : (ref_mem[u][idx] & mask);

    @(negedge clk);
    check("dready_idle", {31'd0, dready_s[u]}, 32'd0);
    dce_s[u] = 1'b1; daddr_s[u] = a; we_s[u] = w; dre_s[u] = r; din_s[u] = d;
    #1;
    check("stall_req", {31'd0, dstall_s[u]}, 32'd1);
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (dready_s[u]) begin
        lat = c;
        break;
      end
      check("stall_wait", {31'd0, dstall_s[u]}, 32'd1);
      daddr_s[u] = $urandom; we_s[u] = 4'($urandom); dre_s[u] = 4'($urandom); din_s[u] = $urandom;
    end
    check("latency", 32'(lat), 32'(1 + wait_of(u)));
    check("dout", dout_s[u], exp);
    check("stall_resp", {31'd0, dstall_s[u]}, 32'd0);
`ifdef DMEM_RANGE_CHK_EN
    check("derr", {31'd0, derr_s[u]}, {31'd0, err});
`endif
    dce_s[u] = 1'b0; we_s[u] = 4'd0; dre_s[u] = 4'd0;
    if (!err) begin
      for (int k = 0; k < 4; k++) if (w[k]) ref_mem[u][idx][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    cpu_rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      dce_s[u] = 1'b0; daddr_s[u] = 32'd0; we_s[u] = 4'd0; dre_s[u] = 4'd0; din_s[u] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_dout", dout_s[u], 32'd0);
      check("rst_dready", {31'd0, dready_s[u]}, 32'd0);
      check("rst_dstall", {31'd0, dstall_s[u]}, 32'd0);
    end
    cpu_rst = 1'b0;

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 64; i++) access(u, 32'(i * 4), 4'hF, 4'h0, $urandom | 32'h1);

    access(0, 32'h10, 4'hF, 4'h0, 32'hDEADBEEF);
    access(0, 32'h10, 4'h0, 4'hF, 32'h0);
    access(0, 32'h10, 4'b0100, 4'h0, 32'h00AA0000);
    access(0, 32'h10, 4'h0, 4'b0100, 32'h0);
    access(0, 32'h13, 4'h0, 4'hF, 32'h0);
    check("lane_merge", ref_mem[0][4], 32'hDEAABEEF);

    access(1, 32'h0, 4'h0, 4'hF, 32'h0);
    access(1, 32'h4, 4'h0, 4'hF, 32'h0);

    access(0, 32'h40, 4'h0, 4'h0, 32'hFFFFFFFF);
    access(0, 32'h40, 4'h0, 4'hF, 32'h0);

    access(0, 32'h20, 4'h0, 4'hF, 32'h0);
    @(negedge clk);
    dce_s[0] = 1'b1; daddr_s[0] = 32'h20; we_s[0] = 4'hF; dre_s[0] = 4'h0; din_s[0] = 32'h12345678;
    @(negedge clk);
    cpu_rst = 1'b1; dce_s[0] = 1'b0;
    @(negedge clk);
    check("midrst_dstall", {31'd0, dstall_s[0]}, 32'd0);
    check("midrst_dready", {31'd0, dready_s[0]}, 32'd0);
    check("midrst_dout", dout_s[0], 32'd0);
    cpu_rst = 1'b0; we_s[0] = 4'd0;
    access(0, 32'h20, 4'h0, 4'hF, 32'h0);

    access(0, 32'h00001000, 4'hF, 4'h0, 32'hCAFEF00D);
    access(0, 32'h0, 4'h0, 4'hF, 32'h0);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 40; i++) begin
        a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
        w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        access(u, a, w, 4'($urandom), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the memory-stage access interface (dce/daddr/we/dre/din). It accepts one byte-lane-masked load or store per handshake and holds the pipeline stalled for a configurable number of wait states. It then commits the write or returns masked read data with a one-cycle completion pulse. It sits between the memory stage and the writeback path, replacing a zero-latency ideal RAM.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; must be a power of two.
ADDR_W, 10, word-index width; must equal log2(DEPTH).
WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.

Ports:
cpu_clk_50M  in   1   clock, all state updates on rising edge
cpu_rst      in   1   synchronous reset, active-high
dce          in   1   access request; held stable by the pipeline while dstall=1
daddr        in   32  byte address; word index = daddr[ADDR_W+1:2]; daddr[1:0] ignored
we           in   4   write lane enables; lane k writes din[8k+7:8k]
dre          in   4   read lane enables; lane k returns word[8k+7:8k]
din          in   32  write data in bus lane order (already byte-arranged by the requester)
dout         out  32  read data; lanes not enabled in dre are forced to 0
dready       out  1   one-cycle pulse: access complete, dout valid
dstall       out  1   pipeline hold request
derr         out  1   range-error pulse; port exists only when DMEM_RANGE_CHK_EN is defined

Behaviour:
- Reset (cpu_rst=1 at an edge):
  - state=IDLE, cnt=0, dout=0, dready=0, derr=0.
  - An in-flight request is dropped with no write.
  - The array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If dce=1, latch daddr/we/dre/din and load cnt=WAIT_CYCLES.
  - Next state is RESP if WAIT_CYCLES=0, otherwise WAIT.
  - If dce=0, stay in IDLE.
- WAIT: cnt decrements each cycle; when cnt==1, next state is RESP.
- Entry edge into RESP, using the latched values:
  - Write lanes with we[k]=1.
  - Register dout = masked read of the pre-write word.
  - If we!=0, write has priority and dout=0 regardless of dre.
  - If we=0 and dre=0, the access is a null access: dout=0 and the handshake still completes.
- RESP: dready=1 for exactly this cycle. Next state is IDLE unconditionally. dce is ignored in RESP because the pipeline advances at the end of RESP.
- dstall is combinational: (IDLE & dce) | WAIT. It is 0 in RESP and in IDLE with dce=0.
- Latency: request first seen in IDLE at cycle T → dready at T+1+WAIT_CYCLES. Back-to-back accesses are therefore spaced 2+WAIT_CYCLES cycles apart.
- dout holds its value between accesses. It changes only at RESP entry or on reset.
- Request inputs changing while in WAIT have no effect; the latched copy is used.

Optional Feature:
DMEM_RANGE_CHK_EN
- Defined:
  - An access with daddr[31:ADDR_W+2] != 0 still completes the handshake with normal latency.
  - No write is performed and dout=0.
  - derr pulses high together with dready.
- Undefined:
  - The derr port is absent and upper address bits are ignored, so addresses wrap modulo DEPTH words.

Test Plan:
- WAIT_CYCLES=2, store: dce=1, daddr=0x10, we=4'hF, din=0xDEADBEEF.
  - dstall high for cycles T..T+2, dready at T+3.
  - A later load of 0x10 with dre=4'hF returns dout=0xDEADBEEF.
- Byte lanes: word 0x10 holds 0xDEADBEEF; store we=4'b0100, din=0x00AA0000; then load dre=4'b0100.
  - Returns dout=0x00AA0000.
  - Full-word read returns 0xDEAABEEF.
- WAIT_CYCLES=0, back-to-back loads of 0x0 and 0x4.
  - dready pulses at T+1 and T+3; dstall=1 at T and T+2, 0 at T+1.
- Reset mid-access: assert cpu_rst during WAIT of a store of 0x12345678 to 0x20.
  - Next cycle dstall=0, dready=0, dout=0.
  - A later read of 0x20 returns the old contents.
- Null access: dce=1, we=0, dre=0 → dready at T+1+WAIT_CYCLES, dout=0, array unchanged.
- DMEM_RANGE_CHK_EN, DEPTH=1024: store to daddr=0x00001000 → derr and dready pulse together, word 0 unchanged. Without the macro, the same store overwrites word 0.
